// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared constants for the stopwatch controller: the width of the state
// code and the encoding of every FSM state. Any code outside the named
// states is treated as corrupt by the controller and recovers to IDLE.
package stopwatch_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 3'd1;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd2;
  localparam logic [STATE_W-1:0] ST_LAP   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/stopwatch_ctrl_key_edge.sv
// key_edge
// Brings one active-low pushbutton into the clk domain through a two-flop
// synchronizer and produces a single-cycle press pulse on each synchronized
// falling edge (button going down).
// Ports:
//   clk    - system clock
//   aclr   - asynchronous active-low reset
//   key_n  - raw pushbutton, active-low, asynchronous to clk
//   press  - one-cycle pulse per press
module key_edge (
  input  logic clk,
  input  logic aclr,
  input  logic key_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic last;

  // All three flops reset to the released level so that leaving reset with
  // the button up never looks like a falling edge.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      last  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      last  <= sync2;
    end
  end

  assign press = last & ~sync2;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control FSM for a stopwatch built around an external BCD counter chain.
// A prescaler divides clk by TICK_DIV and, while running, pulses cnt_inc to
// the chain on each wrap. When the chain reports terminal count at a wrap
// the increment is withheld and the FSM parks in DONE so the display stays
// at all nines. A lap view freezes the display latch while counting goes on.
// Optional feature macro: STOPWATCH_LAP_EN enables the lap key and LAP state;
// without it key_lap_n is ignored and disp_hold is tied low.
// Parameters:
//   TICK_DIV    - clk cycles per count increment (>= 2)
// Ports:
//   clk         - system clock, rising edge
//   aclr        - asynchronous active-low reset
//   key_start_n - start/stop button, active-low, asynchronous
//   key_lap_n   - lap button, active-low, asynchronous
//   key_clear_n - clear button, active-low, asynchronous
//   tc_in       - counter chain at terminal count
//   cnt_inc     - one-cycle increment strobe to the chain
//   cnt_clr     - one-cycle synchronous clear strobe to the chain
//   disp_hold   - display latch frozen (lap view)
//   state       - current FSM state code
//   done        - high while in DONE
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               key_start_n,
  input  logic               key_lap_n,
  input  logic               key_clear_n,
  input  logic               tc_in,
  output logic               cnt_inc,
  output logic               cnt_clr,
  output logic               disp_hold,
  output logic [STATE_W-1:0] state,
  output logic               done
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic              start_press;
  logic              lap_press;
  logic              clear_press;
  logic              start_evt;
  logic              lap_evt;
  logic              clear_evt;
  logic [PW-1:0]     presc;
  logic [PW-1:0]     presc_next;
  logic [STATE_W-1:0] next_state;
  logic              do_clr;
  logic              counting;
  logic              wrap;

  key_edge u_start (.clk(clk), .aclr(aclr), .key_n(key_start_n), .press(start_press));
  key_edge u_lap   (.clk(clk), .aclr(aclr), .key_n(key_lap_n),   .press(lap_press));
  key_edge u_clear (.clk(clk), .aclr(aclr), .key_n(key_clear_n), .press(clear_press));

  // Same-cycle presses resolve as clear > start > lap; the losers are
  // dropped outright, even if the winner turns out to be ignored in the
  // current state.
  assign clear_evt = clear_press;
  assign start_evt = start_press & ~clear_press;
`ifdef STOPWATCH_LAP_EN
  assign lap_evt   = lap_press & ~clear_press & ~start_press;
`else
  assign lap_evt   = lap_press & 1'b0;
`endif

  assign counting = (state == ST_RUN) || (state == ST_LAP);
  assign wrap     = counting && (presc == PRESC_MAX);

  // A terminal wrap outranks any key so the chain can never step past 999.
  // A non-terminal wrap coinciding with a key still yields its increment.
  always_comb begin
    next_state = state;
    do_clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_evt)      do_clr = 1'b1;
        else if (start_evt) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (wrap && tc_in)  next_state = ST_DONE;
        else if (start_evt) next_state = ST_PAUSE;
        else if (lap_evt)   next_state = ST_LAP;
      end
      ST_PAUSE: begin
        if (clear_evt) begin
          do_clr     = 1'b1;
          next_state = ST_IDLE;
        end else if (start_evt) begin
          next_state = ST_RUN;
        end
      end
      ST_LAP: begin
        if (wrap && tc_in)  next_state = ST_DONE;
        else if (start_evt) next_state = ST_PAUSE;
        else if (lap_evt)   next_state = ST_RUN;
      end
      ST_DONE: begin
        if (clear_evt) begin
          do_clr     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Prescaler restarts on a fresh start and on every clear so the first
  // increment after either is a full period away; PAUSE simply holds it.
  always_comb begin
    presc_next = presc;
    if (do_clr || (state == ST_IDLE && next_state == ST_RUN)) presc_next = '0;
    else if (wrap)                                            presc_next = '0;
    else if (counting)                                        presc_next = presc + PW'(1);
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state     <= ST_IDLE;
      presc     <= '0;
      cnt_inc   <= 1'b0;
      cnt_clr   <= 1'b0;
      disp_hold <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      presc     <= presc_next;
      cnt_inc   <= wrap & ~tc_in;
      cnt_clr   <= do_clr;
      done      <= (next_state == ST_DONE);
`ifdef STOPWATCH_LAP_EN
      disp_hold <= (next_state == ST_LAP);
`else
      disp_hold <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per count increment (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port aclr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port key_start_n  input  1  start/stop pushbutton, active-low, asynchronous to clk.
REQ-005 SHALL have port key_lap_n  input  1  lap pushbutton, active-low, asynchronous.
REQ-006 SHALL have port key_clear_n  input  1  clear pushbutton, active-low, asynchronous.
REQ-007 SHALL have port tc_in  input  1  high when the external BCD counter chain is at terminal count (all digits 9).
REQ-008 SHALL have port cnt_inc  output  1  one-cycle increment strobe to the counter chain.
REQ-009 SHALL have port cnt_clr  output  1  one-cycle synchronous clear strobe to the counter chain.
REQ-010 SHALL have port disp_hold  output  1  high = display latch frozen (lap view).
REQ-011 SHALL have port state  output  3  current FSM state code.
REQ-012 SHALL have port done  output  1  high while in DONE.

Function
REQ-013 SHALL pass each key through a two-flop synchronizer, then generate a one-cycle press pulse on each synchronized falling edge.
REQ-014 SHALL encode states: IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4; codes 5-7 SHALL recover to IDLE.
REQ-015 SHALL register all outputs; cnt_inc, cnt_clr and disp_hold change one cycle after the causing press or prescaler event.
REQ-016 SHALL run a prescaler 0..TICK_DIV-1 that counts only in RUN and LAP and holds its value in PAUSE.
REQ-017 SHALL zero the prescaler on IDLE->RUN and on every cnt_clr.
REQ-018 SHALL pulse cnt_inc when the prescaler wraps, if tc_in=0.
REQ-019 SHALL instead suppress cnt_inc and enter DONE when the prescaler wraps with tc_in=1, so the counters stay at 999.
REQ-020 SHALL transition IDLE->RUN on start; PAUSE->RUN on start; RUN->PAUSE on start; RUN->LAP on lap; LAP->RUN on lap; LAP->PAUSE on start; LAP->DONE on terminal wrap.
REQ-021 SHALL, on clear in IDLE, PAUSE or DONE, pulse cnt_clr and go to IDLE; clear in RUN or LAP SHALL be ignored.
REQ-022 SHALL ignore start and lap in DONE, and lap in IDLE and PAUSE.
REQ-023 SHALL resolve same-cycle presses with priority clear > start > lap; lower-priority presses SHALL be discarded, not queued.
REQ-024 SHALL assert disp_hold exactly while in LAP; counting continues underneath.
REQ-025 SHALL, when a prescaler wrap and a start press coincide in RUN, issue the cnt_inc and also enter PAUSE.

Reset
REQ-026 SHALL, on aclr low, force state IDLE, prescaler 0, synchronizer flops to released (1), and cnt_inc, cnt_clr, disp_hold, done all 0.
REQ-027 SHALL not generate a press pulse on the first edges after aclr release while keys are still released.

Configuration
REQ-028 SHALL honour macro STOPWATCH_LAP_EN: when defined, the lap function operates as specified; when undefined, key_lap_n is ignored, LAP is unreachable, and disp_hold is tied 0.

Structure
REQ-029 SHALL take state codes and the state-width constant from package stopwatch_pkg.
REQ-030 SHALL implement the synchronizer plus edge detector as sub-module key_edge, instantiated once per key.

Verification (TICK_DIV=4)
REQ-031 SHALL check: reset, start press -> state=1 within 4 cycles, cnt_inc every 4th cycle thereafter.
REQ-032 SHALL check: start in RUN -> PAUSE, no cnt_inc; start again -> next cnt_inc after the remaining prescaler count only.
REQ-033 SHALL check: tc_in=1 in RUN -> at wrap no cnt_inc, state=4, done=1; clear -> one cnt_clr pulse, state=0.
REQ-034 SHALL check: lap in RUN -> disp_hold=1 with cnt_inc continuing; lap again -> disp_hold=0; lap-disabled build -> disp_hold stays 0.
REQ-035 SHALL check: simultaneous clear+start in PAUSE -> cnt_clr, state=0; clear in RUN -> ignored.
REQ-036 SHALL check: aclr asserted mid-RUN -> all outputs 0 immediately, state=0.
